// File: rtl/traffic_pkg.sv
// Shared phase codes, road constants and lamp decode for the intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        GRN_A   = 3'd0,
        YEL_A   = 3'd1,
        CLR_A   = 3'd2,
        GRN_B   = 3'd3,
        YEL_B   = 3'd4,
        CLR_B   = 3'd5,
        WALK_PH = 3'd6
    } phase_t;

    localparam logic ROAD_A = 1'b0;
    localparam logic ROAD_B = 1'b1;

    typedef struct packed {
        logic ra;
        logic ya;
        logic ga;
        logic rb;
        logic yb;
        logic gb;
        logic walk;
    } lamps_t;

    function automatic phase_t grn_of(input logic road);
        return (road == ROAD_B) ? GRN_B : GRN_A;
    endfunction

    // Every phase lights exactly one lamp per road; unknown codes fall back to all-red.
    function automatic lamps_t lamp_decode(input phase_t p);
        lamps_t l;
        l = '0;
        case (p)
            GRN_A:   begin l.ga = 1'b1; l.rb = 1'b1; end
            YEL_A:   begin l.ya = 1'b1; l.rb = 1'b1; end
            GRN_B:   begin l.ra = 1'b1; l.gb = 1'b1; end
            YEL_B:   begin l.ra = 1'b1; l.yb = 1'b1; end
            WALK_PH: begin l.ra = 1'b1; l.rb = 1'b1; l.walk = 1'b1; end
            default: begin l.ra = 1'b1; l.rb = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Phase dwell counter: synchronous clear, saturating increment, equality compare.
module dwell_timer #(
    parameter int CNT_W = 8,
    parameter int SAT   = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] cnt,
    output logic             eq
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign eq = (cnt == target);

endmodule

// File: rtl/intersection_scheduler.sv
// Timed, demand-driven two-road phase scheduler with pedestrian walk and emergency override.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int WALK      = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TA,
    input  logic       TB,
    input  logic       ped_req,
    input  logic       emg_req,
    input  logic       emg_dir,
    output logic       RA,
    output logic       YA,
    output logic       GA,
    output logic       RB,
    output logic       YB,
    output logic       GB,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    phase_t             phase_q, phase_d;
    logic               pend_q;
    logic               ack_q;
    logic               last_q;
    logic               road_cur;
    logic               tx, ty;
    logic               enter_walk;
    logic [CNT_W-1:0]   target;
    logic [CNT_W-1:0]   cnt;
    logic               dwell_done;
    lamps_t             lamps;

    dwell_timer #(
        .CNT_W (CNT_W),
        .SAT   (MAX_GREEN - 1)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (phase_d != phase_q),
        .target (target),
        .cnt    (cnt),
        .eq     (dwell_done)
    );

    always_comb begin
        phase_d  = phase_q;
        target   = '0;
        road_cur = (phase_q == GRN_B || phase_q == YEL_B || phase_q == CLR_B) ? ROAD_B : ROAD_A;
        tx       = (road_cur == ROAD_B) ? TB : TA;
        ty       = (road_cur == ROAD_B) ? TA : TB;
        case (phase_q)
            GRN_A, GRN_B: begin
                // An emergency for the other road preempts; one for this road pins the green.
                target = CNT_W'(MAX_GREEN - 1);
                if (emg_req && emg_dir != road_cur) begin
                    phase_d = (road_cur == ROAD_B) ? YEL_B : YEL_A;
                end else if (!(emg_req && emg_dir == road_cur) &&
                             cnt >= CNT_W'(MIN_GREEN - 1) &&
                             (ty || pend_q) && (!tx || dwell_done)) begin
                    phase_d = (road_cur == ROAD_B) ? YEL_B : YEL_A;
                end
            end
            YEL_A, YEL_B: begin
                target = CNT_W'(YELLOW - 1);
                if (dwell_done) phase_d = (road_cur == ROAD_B) ? CLR_B : CLR_A;
            end
            CLR_A, CLR_B: begin
                target = CNT_W'(ALL_RED - 1);
                if (dwell_done) begin
                    if (pend_q && !emg_req) phase_d = WALK_PH;
                    else if (emg_req)       phase_d = grn_of(emg_dir);
                    else                    phase_d = grn_of(~road_cur);
                end
            end
            WALK_PH: begin
                target = CNT_W'(WALK - 1);
                if (dwell_done) phase_d = emg_req ? grn_of(emg_dir) : grn_of(~last_q);
            end
            default: phase_d = GRN_A;
        endcase
    end

    assign enter_walk = (phase_d == WALK_PH) && (phase_q != WALK_PH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= GRN_A;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            last_q  <= ROAD_B;
        end else begin
            phase_q <= phase_d;
            ack_q   <= enter_walk;
            // Walk entry wins over a same-cycle request so it is absorbed, not re-armed.
            if (enter_walk)
                pend_q <= 1'b0;
            else if (ped_req && phase_q != WALK_PH)
                pend_q <= 1'b1;
            if ((phase_q == CLR_A || phase_q == CLR_B) && phase_d != phase_q)
                last_q <= road_cur;
        end
    end

    assign lamps   = lamp_decode(phase_q);
    assign RA      = lamps.ra;
    assign YA      = lamps.ya;
    assign GA      = lamps.ga;
    assign RB      = lamps.rb;
    assign YB      = lamps.yb;
    assign GB      = lamps.gb;
    assign walk    = lamps.walk;
    assign ped_ack = ack_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed and randomized bench for intersection_scheduler against a road/stage reference model.
module tb_intersection_scheduler;

    localparam int MIN_GREEN = 5;
    localparam int MAX_GREEN = 20;
    localparam int YELLOW    = 3;
    localparam int ALL_RED   = 2;
    localparam int WALK      = 4;
    localparam int CNT_W     = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic TA = 1'b0, TB = 1'b0, ped_req = 1'b0, emg_req = 1'b0, emg_dir = 1'b0;
    logic RA, YA, GA, RB, YB, GB, walk, ped_ack;
    logic [2:0] phase;

    always #5 clk = ~clk;

    intersection_scheduler #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW    (YELLOW),
        .ALL_RED   (ALL_RED),
        .WALK      (WALK),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .TA      (TA),
        .TB      (TB),
        .ped_req (ped_req),
        .emg_req (emg_req),
        .emg_dir (emg_dir),
        .RA      (RA),
        .YA      (YA),
        .GA      (GA),
        .RB      (RB),
        .YB      (YB),
        .GB      (GB),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which road owns the cycle, which stage it is in
    // (0 green, 1 yellow, 2 all-red, 3 walk) and how many edges since entry.
    int m_road, m_stage, m_el, m_last;
    bit m_pend, m_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_road = 0; m_stage = 0; m_el = 0; m_last = 1; m_pend = 0; m_ack = 0;
    endfunction

    function automatic void model_update();
        int  ns, nr, own, oth;
        bit  emg_here, emg_other;
        ns = m_stage; nr = m_road;
        own = (m_road == 1) ? int'(TB) : int'(TA);
        oth = (m_road == 1) ? int'(TA) : int'(TB);
        emg_here  = emg_req && (int'(emg_dir) == m_road);
        emg_other = emg_req && (int'(emg_dir) != m_road);
        case (m_stage)
            0: if (emg_other ||
                   (!emg_here && m_el + 1 >= MIN_GREEN && (oth != 0 || m_pend) &&
                    (own == 0 || m_el + 1 >= MAX_GREEN))) ns = 1;
            1: if (m_el + 1 >= YELLOW) ns = 2;
            2: if (m_el + 1 >= ALL_RED) begin
                   m_last = m_road;
                   if (m_pend && !emg_req) ns = 3;
                   else begin ns = 0; nr = emg_req ? int'(emg_dir) : 1 - m_road; end
               end
            default: if (m_el + 1 >= WALK) begin
                   ns = 0; nr = emg_req ? int'(emg_dir) : 1 - m_last;
               end
        endcase
        if (ns == 3 && m_stage != 3) begin
            m_pend = 0; m_ack = 1;
        end else begin
            m_ack = 0;
            if (ped_req && m_stage != 3) m_pend = 1;
        end
        m_el    = (ns != m_stage || nr != m_road) ? 0 : m_el + 1;
        m_stage = ns;
        m_road  = nr;
    endfunction

    function automatic logic [6:0] exp_lamps();
        logic [2:0] a, b, lit;
        a = 3'b100; b = 3'b100;
        if (m_stage != 3) begin
            lit = (m_stage == 0) ? 3'b001 : (m_stage == 1) ? 3'b010 : 3'b100;
            if (m_road == 0) a = lit; else b = lit;
        end
        return {a, b, m_stage == 3};
    endfunction

    task automatic check_all();
        chk("phase", 32'(phase), (m_stage == 3) ? 32'd6 : 32'(m_road * 3 + m_stage));
        chk("lamps", 32'({RA, YA, GA, RB, YB, GB, walk}), 32'(exp_lamps()));
        chk("ped_ack", 32'(ped_ack), 32'(m_ack));
        chk("one_lamp_per_road", 32'($countones({RA, YA, GA}) == 1 && $countones({RB, YB, GB}) == 1), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until(input logic [2:0] p, output int edges);
        edges = 0;
        while (phase !== p && edges < 200) begin
            step();
            edges++;
        end
        chk("reach_phase", 32'(phase), 32'(p));
    endtask

    initial begin
        int e, ga_n, ya_n, gb_n, yb_n, ar_n, walk_n, ack_n;

        // Reset, then road A traffic only: green A holds.
        #1;
        TA = 1'b1; TB = 1'b0;
        do_reset();
        chk("reset_lamps", 32'({RA, YA, GA, RB, YB, GB, walk, ped_ack}), 32'b00110000);
        chk("reset_phase", 32'(phase), 32'd0);
        ga_n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (GA && RB && phase == 3'd0) ga_n++;
        end
        chk("grn_a_rest", 32'(ga_n), 32'd50);

        // Road B demand only: A yields after minimum green.
        do_reset();
        TA = 1'b0; TB = 1'b1;
        run_until(3'd1, e); chk("edges_to_yel_a", 32'(e), 32'(MIN_GREEN));
        run_until(3'd2, e); chk("edges_to_clr_a", 32'(e), 32'(YELLOW));
        run_until(3'd3, e); chk("edges_to_grn_b", 32'(e), 32'(ALL_RED));

        // Both roads busy: alternate on the maximum green.
        TA = 1'b1; TB = 1'b1;
        do_reset();
        ga_n = int'(GA); ya_n = 0; gb_n = 0; yb_n = 0; ar_n = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            ga_n += int'(GA); ya_n += int'(YA); gb_n += int'(GB); yb_n += int'(YB);
            ar_n += int'(RA && RB);
        end
        chk("ga_cycles", 32'(ga_n), 32'(MAX_GREEN));
        chk("ya_cycles", 32'(ya_n), 32'(YELLOW));
        chk("gb_cycles", 32'(gb_n), 32'(MAX_GREEN));
        chk("yb_cycles", 32'(yb_n), 32'(YELLOW));
        chk("allred_cycles", 32'(ar_n), 32'(2 * ALL_RED));

        // Single pedestrian pulse with no traffic.
        TA = 1'b0; TB = 1'b0;
        do_reset();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        walk_n = 0; ack_n = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            walk_n += int'(walk); ack_n += int'(ped_ack);
        end
        chk("walk_cycles", 32'(walk_n), 32'(WALK));
        chk("ack_pulses", 32'(ack_n), 32'd1);
        chk("after_walk_grn_b", 32'(phase), 32'd3);

        // Emergency for B at green A cnt = 1, with pedestrian pending.
        TA = 1'b1; TB = 1'b0;
        do_reset();
        step();
        emg_req = 1'b1; emg_dir = 1'b1; ped_req = 1'b1;
        step();
        chk("emg_yel_a", 32'(phase), 32'd1);
        ped_req = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("emg_hold_grn_b", 32'(phase), 32'd3);
        emg_req = 1'b0;
        run_until(3'd4, e);

        // Asynchronous reset mid-yellow B with a pending request.
        ped_req = 1'b1;
        step();
        do_reset();
        ped_req = 1'b0;
        chk("rst_ga_rb", 32'({GA, RB, ped_ack}), 32'b110);
        TA = 1'b0; TB = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("pending_cleared", 32'(phase), 32'd0);

        // Randomized traffic, requests, emergencies and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) TA = ~TA;
            if ($urandom_range(0, 11) == 0) TB = ~TB;
            ped_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 39) == 0) begin
                emg_req = ~emg_req;
                emg_dir = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
